ddr_bank_timer: RTL and testbench

Parametrised per-bank timing tracker for the DDR4 controller. It extends the controller's shared ready/delay signalling (act/cas/pre ready, tCCD and similar delays) from a single global view into per-bank state machines with their own countdown timers. It sits between the command scheduler and the command encoder. The scheduler only issues a command to a bank when that bank's ready bit is set.

---
 rtl/ddr_package.sv | 27 ++
 rtl/ddr_bank_fsm.sv | 80 ++++++++
 rtl/ddr_bank_timer.sv | 151 +++++++++++++++
 tb/tb_ddr_bank_timer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_package.sv
// Shared command/state encodings and power-on timing defaults for the DDR bank timer.
package ddr_package;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } bank_cmd_type;

  typedef enum logic [1:0] {
    B_IDLE,
    B_ACTIVATING,
    B_ACTIVE,
    B_PRECHARGING
  } bank_state_type;

  localparam int DEF_TRCD = 1;
  localparam int DEF_TRP  = 1;
  localparam int DEF_TRAS = 1;
  localparam int DEF_TCCD = 1;
  localparam int DEF_TRFC = 1;

endpackage

// File: rtl/ddr_bank_fsm.sv
// One bank's row state with its rcd/ras/rp down-counters.
//   state         | meaning
//   B_IDLE        | no row open, ACT allowed
//   B_ACTIVATING  | row opening, rcd counting down
//   B_ACTIVE      | row open, RD/WR allowed, PRE once ras hits 0
//   B_PRECHARGING | row closing, rp counting down
module ddr_bank_fsm
  import ddr_package::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic [CNT_W-1:0] trcd_i,
  input  logic [CNT_W-1:0] tras_i,
  input  logic [CNT_W-1:0] trp_i,
  output logic             idle_o,
  output logic             active_o,
  output logic             pre_ok_o,
  output logic             open_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  bank_state_type   state_q;
  logic [CNT_W-1:0] rcd_q, ras_q, rp_q;
  logic [CNT_W-1:0] rcd_ld, ras_ld, rp_ld;

  // Timing values 0 and 1 both load 0 so the dependent command is legal next cycle.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
    return (t > ONE) ? t - ONE : '0;
  endfunction

  assign rcd_ld = load_val(trcd_i);
  assign ras_ld = load_val(tras_i);
  assign rp_ld  = load_val(trp_i);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= B_IDLE;
      rcd_q   <= '0;
      ras_q   <= '0;
      rp_q    <= '0;
    end else begin
      if (ras_q != '0) ras_q <= ras_q - ONE;
      case (state_q)
        B_IDLE: begin
          if (act_i) begin
            rcd_q   <= rcd_ld;
            ras_q   <= ras_ld;
            state_q <= (rcd_ld == '0) ? B_ACTIVE : B_ACTIVATING;
          end
        end
        B_ACTIVATING: begin
          if (rcd_q != '0) rcd_q <= rcd_q - ONE;
          if (rcd_q <= ONE) state_q <= B_ACTIVE;
        end
        B_ACTIVE: begin
          if (pre_i) begin
            rp_q    <= rp_ld;
            state_q <= (rp_ld == '0) ? B_IDLE : B_PRECHARGING;
          end
        end
        B_PRECHARGING: begin
          if (rp_q != '0) rp_q <= rp_q - ONE;
          if (rp_q <= ONE) state_q <= B_IDLE;
        end
        default: state_q <= B_IDLE;
      endcase
    end
  end

  assign idle_o   = (state_q == B_IDLE);
  assign active_o = (state_q == B_ACTIVE);
  assign pre_ok_o = (state_q == B_ACTIVE) && (ras_q == '0);
  assign open_o   = (state_q == B_ACTIVATING) || (state_q == B_ACTIVE);

endmodule

// File: rtl/ddr_bank_timer.sv
// Per-bank DDR timing tracker: bank FSMs plus global ccd/rfc timers and timing config.
// Optional violation monitor outputs are enabled with TIMING_VIOLATION_CHK_EN.
module ddr_bank_timer
  import ddr_package::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int CNT_W     = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         cfg_load,
  input  logic [CNT_W-1:0]             cfg_trcd,
  input  logic [CNT_W-1:0]             cfg_trp,
  input  logic [CNT_W-1:0]             cfg_tras,
  input  logic [CNT_W-1:0]             cfg_tccd,
  input  logic [CNT_W-1:0]             cfg_trfc,
  input  logic                         cmd_valid,
  input  logic [2:0]                   cmd_type,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic [NUM_BANKS-1:0]         act_rdy,
  output logic [NUM_BANKS-1:0]         cas_rdy,
  output logic [NUM_BANKS-1:0]         pre_rdy,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         ref_rdy,
  output logic                         all_idle
`ifdef TIMING_VIOLATION_CHK_EN
  ,
  output logic                         viol_pulse,
  output logic [15:0]                  viol_count
`endif
);

  localparam int               BW  = $clog2(NUM_BANKS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
    return (t > ONE) ? t - ONE : '0;
  endfunction

  bank_cmd_type         cmd_e;
  logic                 cmd_ok, rdwr_go, ref_go, refreshing;
  logic [NUM_BANKS-1:0] act_go, pre_go, idle, active, pre_ok;

  logic [CNT_W-1:0] trcd_q, trp_q, tras_q, tccd_q, trfc_q, ccd_q, rfc_q;
  logic [CNT_W-1:0] trcd_d, trp_d, tras_d, tccd_d, trfc_d, ccd_d, rfc_d;

  assign cmd_e = bank_cmd_type'(cmd_type);

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_e)
      CMD_ACT:        cmd_ok = act_rdy[cmd_bank];
      CMD_RD, CMD_WR: cmd_ok = cas_rdy[cmd_bank];
      CMD_PRE:        cmd_ok = pre_rdy[cmd_bank];
      CMD_PREA:       cmd_ok = |pre_rdy;
      CMD_REF:        cmd_ok = ref_rdy;
      default:        cmd_ok = 1'b0;
    endcase
  end

  assign rdwr_go = cmd_valid && cmd_ok && ((cmd_e == CMD_RD) || (cmd_e == CMD_WR));
  assign ref_go  = cmd_valid && cmd_ok && (cmd_e == CMD_REF);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign act_go[b] = cmd_valid && cmd_ok && (cmd_e == CMD_ACT) && (cmd_bank == BW'(b));
    assign pre_go[b] = cmd_valid && pre_rdy[b] &&
                       (((cmd_e == CMD_PRE) && (cmd_bank == BW'(b))) || (cmd_e == CMD_PREA));

    ddr_bank_fsm #(.CNT_W(CNT_W)) u_bank (
      .clock    (clock),
      .reset_n  (reset_n),
      .act_i    (act_go[b]),
      .pre_i    (pre_go[b]),
      .trcd_i   (trcd_q),
      .tras_i   (tras_q),
      .trp_i    (trp_q),
      .idle_o   (idle[b]),
      .active_o (active[b]),
      .pre_ok_o (pre_ok[b]),
      .open_o   (bank_open[b])
    );
  end

  always_comb begin
    trcd_d = trcd_q;
    trp_d  = trp_q;
    tras_d = tras_q;
    tccd_d = tccd_q;
    trfc_d = trfc_q;
    if (cfg_load && all_idle) begin
      trcd_d = cfg_trcd;
      trp_d  = cfg_trp;
      tras_d = cfg_tras;
      tccd_d = cfg_tccd;
      trfc_d = cfg_trfc;
    end
    ccd_d = (ccd_q != '0) ? ccd_q - ONE : '0;
    if (rdwr_go) ccd_d = load_val(tccd_q);
    rfc_d = (rfc_q != '0) ? rfc_q - ONE : '0;
    if (ref_go) rfc_d = load_val(trfc_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trcd_q <= CNT_W'(DEF_TRCD);
      trp_q  <= CNT_W'(DEF_TRP);
      tras_q <= CNT_W'(DEF_TRAS);
      tccd_q <= CNT_W'(DEF_TCCD);
      trfc_q <= CNT_W'(DEF_TRFC);
      ccd_q  <= '0;
      rfc_q  <= '0;
    end else begin
      trcd_q <= trcd_d;
      trp_q  <= trp_d;
      tras_q <= tras_d;
      tccd_q <= tccd_d;
      trfc_q <= trfc_d;
      ccd_q  <= ccd_d;
      rfc_q  <= rfc_d;
    end
  end

  // Refresh is in progress exactly while the rfc timer is non-zero.
  assign refreshing = (rfc_q != '0);
  assign act_rdy    = idle & {NUM_BANKS{!refreshing}};
  assign cas_rdy    = active & {NUM_BANKS{ccd_q == '0}};
  assign pre_rdy    = pre_ok;
  assign ref_rdy    = (&idle) && !refreshing;
  assign all_idle   = ref_rdy;

`ifdef TIMING_VIOLATION_CHK_EN
  logic        viol, viol_pulse_q;
  logic [15:0] viol_count_q;

  assign viol = cmd_valid && (cmd_e != CMD_NOP) && !cmd_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      viol_pulse_q <= 1'b0;
      viol_count_q <= '0;
    end else begin
      viol_pulse_q <= viol;
      if (viol && (viol_count_q != 16'hFFFF)) viol_count_q <= viol_count_q + 16'd1;
    end
  end

  assign viol_pulse = viol_pulse_q;
  assign viol_count = viol_count_q;
`endif

endmodule

// File: tb/tb_ddr_bank_timer.sv
// Scoreboard bench for ddr_bank_timer: the driver queues expected outputs per cycle, a monitor compares them.
module tb_ddr_bank_timer;
  import ddr_package::*;

  localparam int NB = 16;
  localparam int CW = 8;
  localparam int BW = 4;

  localparam int S_ACT = 0, S_CAS = 1, S_PRE = 2, S_OPEN = 3;
  localparam int S_REF = 4, S_IDLE = 5, S_VP = 6, S_VC = 7;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_load = 1'b0;
  logic [CW-1:0] cfg_trcd = '0, cfg_trp = '0, cfg_tras = '0, cfg_tccd = '0, cfg_trfc = '0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_type = '0;
  logic [BW-1:0] cmd_bank = '0;
  logic [NB-1:0] act_rdy, cas_rdy, pre_rdy, bank_open;
  logic          ref_rdy, all_idle;
`ifdef TIMING_VIOLATION_CHK_EN
  logic          viol_pulse;
  logic [15:0]   viol_count;
`endif

  ddr_bank_timer #(.NUM_BANKS(NB), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_load  (cfg_load),
    .cfg_trcd  (cfg_trcd),
    .cfg_trp   (cfg_trp),
    .cfg_tras  (cfg_tras),
    .cfg_tccd  (cfg_tccd),
    .cfg_trfc  (cfg_trfc),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_bank  (cmd_bank),
    .act_rdy   (act_rdy),
    .cas_rdy   (cas_rdy),
    .pre_rdy   (pre_rdy),
    .bank_open (bank_open),
    .ref_rdy   (ref_rdy),
    .all_idle  (all_idle)
`ifdef TIMING_VIOLATION_CHK_EN
    ,
    .viol_pulse(viol_pulse),
    .viol_count(viol_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t sb[$];
  int   errors = 0;
  int   checks = 0;
  event ev_now;

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      S_ACT:  v = 32'(act_rdy);
      S_CAS:  v = 32'(cas_rdy);
      S_PRE:  v = 32'(pre_rdy);
      S_OPEN: v = 32'(bank_open);
      S_REF:  v = 32'(ref_rdy);
      S_IDLE: v = 32'(all_idle);
`ifdef TIMING_VIOLATION_CHK_EN
      S_VP:   v = 32'(viol_pulse);
      S_VC:   v = 32'(viol_count);
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic compare(input chk_t c);
    logic [31:0] a;
    a = observe(c.sel);
    checks++;
    if (a !== c.exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", c.nm, cyc, a, c.exp);
    end
  endtask

  // now = -1 selects the entries queued for an immediate, off-clock sample.
  task automatic scan(input int now);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == now) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (now >= 0 && sb[i].cyc >= 0 && sb[i].cyc < now) begin
        checks++;
        errors++;
        $display("FAIL %s: never sampled (due cycle %0d)", sb[i].nm, sb[i].cyc);
        sb.delete(i);
      end
    end
  endtask

  always @(negedge clock) scan(cyc);
  always @(ev_now) scan(-1);

  task automatic exp_at(input int c, input int sel, input logic [31:0] v, input string nm);
    chk_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue(input int ty, input int bank);
    cmd_valid = 1'b1;
    cmd_type  = 3'(ty);
    cmd_bank  = BW'(bank);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_type  = '0;
    cmd_bank  = '0;
  endtask

  task automatic load_cfg(input int rcd, input int rp, input int ras, input int ccd, input int rfc);
    cfg_trcd = CW'(rcd);
    cfg_trp  = CW'(rp);
    cfg_tras = CW'(ras);
    cfg_tccd = CW'(ccd);
    cfg_trfc = CW'(rfc);
    cfg_load = 1'b1;
    @(negedge clock);
    cfg_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, u, p, r, a, b;

    wait_cyc(3);
    reset_n = 1'b1;
    t = cyc;
    exp_at(t + 1, S_ACT,  32'hFFFF, "rst_act_rdy");
    exp_at(t + 1, S_CAS,  32'h0,    "rst_cas_rdy");
    exp_at(t + 1, S_PRE,  32'h0,    "rst_pre_rdy");
    exp_at(t + 1, S_OPEN, 32'h0,    "rst_bank_open");
    exp_at(t + 1, S_REF,  32'h1,    "rst_ref_rdy");
    exp_at(t + 1, S_IDLE, 32'h1,    "rst_all_idle");
`ifdef TIMING_VIOLATION_CHK_EN
    exp_at(t + 1, S_VC,   32'h0,    "rst_viol_count");
`endif
    wait_cyc(2);

    // ACT 3 (trcd=4), ACT 5, then global tccd blocking
    load_cfg(4, 1, 4, 4, 1);
    t = cyc;
    exp_at(t + 1, S_OPEN, 32'h0008, "act3_open");
    exp_at(t + 1, S_ACT,  32'hFFF7, "act3_act_rdy");
    exp_at(t + 1, S_REF,  32'h0,    "act3_ref_rdy");
    exp_at(t + 2, S_OPEN, 32'h0028, "act5_open");
    exp_at(t + 3, S_CAS,  32'h0,    "act3_cas_early");
    exp_at(t + 4, S_CAS,  32'h0008, "act3_cas_trcd");
    exp_at(t + 4, S_PRE,  32'h0008, "act3_pre_tras");
    issue(CMD_ACT, 3);
    issue(CMD_ACT, 5);
    wait_cyc(3);

    u = cyc;
    exp_at(u + 1, S_CAS, 32'h0,    "rd3_ccd_block");
    exp_at(u + 3, S_CAS, 32'h0,    "rd5_discarded");
    exp_at(u + 4, S_CAS, 32'h0028, "ccd_expired");
`ifdef TIMING_VIOLATION_CHK_EN
    exp_at(u + 1, S_VP, 32'h0, "rd3_no_viol");
    exp_at(u + 3, S_VP, 32'h1, "rd5_viol_pulse");
    exp_at(u + 3, S_VC, 32'h1, "rd5_viol_count");
`endif
    issue(CMD_RD, 3);
    wait_cyc(1);
    issue(CMD_RD, 5);
    wait_cyc(1);

    p = cyc;
    exp_at(p + 1, S_ACT,  32'hFFFF, "prea_trp1_idle");
    exp_at(p + 1, S_OPEN, 32'h0,    "prea_closed");
    issue(CMD_PREA, 0);
    wait_cyc(1);

    // tras=10 / trp=5 on bank 0, plus tccd=1 back-to-back CAS
    load_cfg(2, 5, 10, 1, 20);
    t = cyc;
    exp_at(t + 2,  S_CAS,  32'h1,    "act0_trcd2");
    exp_at(t + 3,  S_CAS,  32'h1,    "rd0_tccd1");
    exp_at(t + 6,  S_PRE,  32'h0,    "pre_before_tras");
    exp_at(t + 7,  S_OPEN, 32'h1,    "pre_early_discard");
    exp_at(t + 10, S_PRE,  32'h1,    "pre_at_tras");
    exp_at(t + 11, S_OPEN, 32'h0,    "pre_accepted");
    exp_at(t + 14, S_ACT,  32'hFFFE, "trp_pending");
    exp_at(t + 15, S_ACT,  32'hFFFF, "trp_done");
    issue(CMD_ACT, 0);
    wait_cyc(1);
    issue(CMD_RD, 0);
    wait_cyc(3);
    issue(CMD_PRE, 0);
    wait_cyc(3);
    issue(CMD_PRE, 0);
    wait_cyc(4);

    // PREA on banks 1,2 then REF with trfc=20
    issue(CMD_ACT, 1);
    issue(CMD_ACT, 2);
    wait_cyc(9);
    p = cyc;
    exp_at(p + 1, S_OPEN, 32'h0,    "prea12_closing");
    exp_at(p + 1, S_ACT,  32'hFFF9, "prea12_precharging");
    exp_at(p + 1, S_PRE,  32'h0,    "prea12_pre_rdy");
    exp_at(p + 4, S_ACT,  32'hFFF9, "prea12_trp_pending");
    exp_at(p + 4, S_REF,  32'h0,    "prea12_ref_low");
    exp_at(p + 5, S_ACT,  32'hFFFF, "prea12_idle");
    exp_at(p + 5, S_REF,  32'h1,    "prea12_ref_rdy");
    issue(CMD_PREA, 0);
    wait_cyc(4);

    r = cyc;
    exp_at(r + 1,  S_ACT,  32'h0,    "ref_act_low");
    exp_at(r + 1,  S_REF,  32'h0,    "ref_ref_low");
    exp_at(r + 1,  S_IDLE, 32'h0,    "ref_all_idle_low");
    exp_at(r + 4,  S_OPEN, 32'h0,    "act_during_ref_discard");
    exp_at(r + 19, S_ACT,  32'h0,    "ref_last_cycle");
    exp_at(r + 20, S_ACT,  32'hFFFF, "ref_done");
    exp_at(r + 20, S_IDLE, 32'h1,    "ref_all_idle");
    issue(CMD_REF, 0);
    wait_cyc(2);
    issue(CMD_ACT, 7);
    wait_cyc(17);

    // cfg_load ignored while bank 4 open, accepted when idle
    t = cyc;
    exp_at(t + 14, S_ACT, 32'hFFEF, "old_trp_kept");
    issue(CMD_ACT, 4);
    load_cfg(0, 0, 0, 3, 20);
    wait_cyc(8);
    issue(CMD_PRE, 4);
    wait_cyc(4);

    a = cyc;
    exp_at(a + 1, S_CAS, 32'h0,  "cfg_ignored_trcd");
    exp_at(a + 2, S_CAS, 32'h10, "old_trcd_used");
    issue(CMD_ACT, 4);
    wait_cyc(9);
    issue(CMD_PRE, 4);
    wait_cyc(4);

    load_cfg(0, 0, 0, 3, 20);
    b = cyc;
    exp_at(b + 1, S_CAS,  32'h10,   "trcd0_cas_next");
    exp_at(b + 1, S_PRE,  32'h10,   "tras0_pre_next");
    exp_at(b + 2, S_CAS,  32'h0,    "rd_next_accepted");
    exp_at(b + 3, S_ACT,  32'hFFFF, "trp0_idle");
    exp_at(b + 3, S_OPEN, 32'h0,    "trp0_closed");
    exp_at(b + 7, S_ACT,  32'h0,    "mid_refresh");
    issue(CMD_ACT, 4);
    issue(CMD_RD, 4);
    issue(CMD_PRE, 4);
    wait_cyc(1);

    // Asynchronous reset in the middle of a refresh
    issue(CMD_REF, 0);
    wait_cyc(3);
    #3;
    reset_n = 1'b0;
    #1;
    exp_at(-1, S_ACT,  32'hFFFF, "async_rst_act_rdy");
    exp_at(-1, S_CAS,  32'h0,    "async_rst_cas_rdy");
    exp_at(-1, S_PRE,  32'h0,    "async_rst_pre_rdy");
    exp_at(-1, S_OPEN, 32'h0,    "async_rst_open");
    exp_at(-1, S_REF,  32'h1,    "async_rst_ref_rdy");
    exp_at(-1, S_IDLE, 32'h1,    "async_rst_all_idle");
`ifdef TIMING_VIOLATION_CHK_EN
    exp_at(-1, S_VC,   32'h0,    "async_rst_viol_count");
`endif
    -> ev_now;
    @(negedge clock);
    reset_n = 1'b1;
    t = cyc;
    exp_at(t + 1, S_OPEN, 32'h0040, "act_after_reset");
    exp_at(t + 1, S_CAS,  32'h0040, "default_trcd_after_reset");
    issue(CMD_ACT, 6);
    wait_cyc(3);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: left unchecked (due cycle %0d)", sb[i].nm, sb[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
